sf3_flash_cmd_sequencer: RTL
============================

// Module: sf3_flash_cmd_sequencer
// PURPOSE
//  Sequences multi-transaction N25Q serial-flash operations onto the single-SPI-mode port of the SF3 quad SPI driver.
//  Accepts one high-level command (read ID, page read, page program, 4 KiB subsector erase), loads the driver TX FIFO and
//  lengths, drains the RX FIFO, and, for program/erase, issues WREN first and polls RDSR until WIP=0.
//  Sits between the tester FSM and the SPI driver.
// PARAMETERS
//  PARM_POLL_GAP   default 2000  idle clocks between successive RDSR polls
//  PARM_POLL_MAX   default 4096  RDSR polls before a program/erase is declared timed out
// PORTS
//  i_clk         in   1   system clock; all logic on its rising edge
//  i_arstn       in   1   reset, asynchronous assert, active-low
//  i_cmd_valid   in   1   command request; held until accepted
//  o_cmd_ready   out  1   high only in S_IDLE; accept = valid & ready
//  i_cmd_op      in   2   00 RDID(0x9F), 01 READ(0x03), 10 PP(0x02), 11 SSE(0x20)
//  i_cmd_addr    in   24  flash byte address (ignored for RDID)
//  i_wr_data     in   8   page-program payload byte
//  i_wr_valid    in   1   payload byte available
//  o_wr_ready    out  1   payload byte consumed this cycle (valid & ready)
//  o_rd_data     out  8   byte read from flash (ID or page data)
//  o_rd_valid    out  1   one-cycle strobe per o_rd_data byte
//  o_cmd_done    out  1   one-cycle pulse at end of every accepted command
//  o_cmd_err     out  1   valid with o_cmd_done; 1 = RDSR poll timeout
//  o_go_stand    out  1   one-cycle pulse: driver starts a single-SPI transaction
//  i_spi_idle    in   1   driver idle; required before o_go_stand
//  o_tx_len      out  11  t_pmod_sf3_tx_len; bytes to transmit
//  o_wait_cyc    out  9   t_pmod_sf3_wait_cyc; always 0 (no dummy cycles in single mode)
//  o_rx_len      out  11  t_pmod_sf3_rx_len; bytes to receive
//  o_tx_data     out  8   t_pmod_sf3_data_byte; TX FIFO write data
//  o_tx_enqueue  out  1   TX FIFO write strobe
//  i_tx_ready    in   1   TX FIFO can accept; o_tx_enqueue only while high
//  i_rx_data     in   8   RX FIFO head byte
//  i_rx_avail    in   1   RX FIFO not empty
//  o_rx_dequeue  out  1   RX FIFO pop strobe; i_rx_data valid the same cycle
// BEHAVIOUR
//  Reset: all outputs 0 except o_cmd_ready=1; state S_IDLE; counters 0. Reset mid-operation aborts immediately;
//   the driver is not told, and the tester must reset it alongside.
//  Accept latches op/addr; o_cmd_ready drops the next cycle. Command lengths (tx/rx): WREN 1/0, RDID 1/3,
//   READ 4/256, PP 260/0, SSE 4/0, RDSR 1/1. o_tx_len/o_rx_len are held stable from the first enqueue
//   until the driver returns idle.
//  States:
//   S_IDLE -> (op PP|SSE) S_WREN_LD; (op RDID|READ) S_CMD_LD.
//   S_WREN_LD: enqueue 0x06 -> S_WREN_GO.
//   S_WREN_GO: o_go_stand when i_spi_idle -> S_WREN_WT.
//   S_WREN_WT: wait for i_spi_idle (sample after >=2 cycles) -> S_CMD_LD.
//   S_CMD_LD: enqueue opcode, then addr[23:16], [15:8], [7:0] (RDID: opcode only). PP -> S_DAT_LD; else -> S_CMD_GO.
//   S_DAT_LD: forward 256 i_wr_data bytes to the TX FIFO. o_wr_ready = i_wr_valid & i_tx_ready; a stalled source
//    waits indefinitely. -> S_CMD_GO.
//   S_CMD_GO: pulse o_go_stand when i_spi_idle -> S_CMD_WT.
//   S_CMD_WT: while rx count < rx_len and i_rx_avail: pop the byte, and on the next cycle o_rd_valid=1 with o_rd_data.
//    Once all bytes are drained and i_spi_idle: PP|SSE -> S_POLL_GAP; else -> S_DONE.
//   S_POLL_GAP: count PARM_POLL_GAP clocks -> S_POLL_LD.
//   S_POLL_LD: enqueue 0x05, then go_stand, then pop the one status byte.
//    bit0=0 -> S_DONE (err=0).
//    bit0=1 and polls < PARM_POLL_MAX -> S_POLL_GAP.
//    bit0=1 otherwise -> S_DONE with err=1.
//   S_DONE: o_cmd_done=1 for one cycle -> S_IDLE. o_cmd_err holds until the next accept.
//  Enqueue strobes occur only when i_tx_ready=1; when it is low, the byte index holds.
//   At most one enqueue and one dequeue per cycle.
//  Counters: byte index 9 bits (0..259 with wrap check at 260 for PP); poll counter is sized
//   $clog2(PARM_POLL_MAX+1) and saturates.
//   PP with addr[7:0]!=0 is passed through unmodified (flash wraps within the page).
//  Back-to-back: a new command can be accepted the cycle after o_cmd_done.
// TESTING
//  RDID, model returns 20 BA 19 -> tx seq {9F}, tx_len=1, rx_len=3; 3 o_rd_valid bytes 20,BA,19; done, err=0.
//  READ addr 0x012300 -> tx {03,01,23,00}, rx_len=256; 256 rd strobes in order; driver never given go while busy.
//  PP addr 0x000100, payload 0..255 with i_wr_valid toggling 50% -> tx {06}, then {02,00,01,00,00..FF} (260B);
//   status 03,03,00 -> 3 polls, spaced by >=PARM_POLL_GAP, then done err=0.
//  SSE with status stuck 0x01, PARM_POLL_MAX=4 -> exactly 4 RDSR transactions, done with err=1.
//  i_tx_ready low for 10 cycles mid PP data -> no byte lost or duplicated (scoreboard compare).
//  i_arstn low mid S_DAT_LD -> outputs reset-valued asynchronously; o_cmd_ready=1 after release; next RDID passes.

Source files
------------

// File: rtl/sf3_flash_cmd_sequencer.sv
`default_nettype none
//==============================================================================
// Module   : sf3_flash_cmd_sequencer
// Purpose  : Turns one high-level N25Q flash command (RDID, READ, PP, SSE) into
//            the sequence of single-SPI transactions on the SF3 driver: loads
//            the TX FIFO and lengths, starts the driver, drains the RX FIFO,
//            and for program/erase issues WREN first and polls RDSR until WIP=0.
// Ports    : i_clk/i_arstn        clock, async active-low reset
//            i_cmd_*/o_cmd_*      command handshake, completion and error
//            i_wr_*/o_wr_ready    page-program payload stream
//            o_rd_data/o_rd_valid read-back byte stream (ID or page data)
//            o_go_stand/i_spi_idle, o_tx_len/o_wait_cyc/o_rx_len
//                                 driver transaction control
//            o_tx_*/i_tx_ready    driver TX FIFO write side
//            i_rx_*/o_rx_dequeue  driver RX FIFO read side
// Revision : 1.0 - initial release
//==============================================================================
module sf3_flash_cmd_sequencer #(
    parameter int PARM_POLL_GAP = 2000,
    parameter int PARM_POLL_MAX = 4096
) (
    input  logic        i_clk,
    input  logic        i_arstn,
    input  logic        i_cmd_valid,
    output logic        o_cmd_ready,
    input  logic [1:0]  i_cmd_op,
    input  logic [23:0] i_cmd_addr,
    input  logic [7:0]  i_wr_data,
    input  logic        i_wr_valid,
    output logic        o_wr_ready,
    output logic [7:0]  o_rd_data,
    output logic        o_rd_valid,
    output logic        o_cmd_done,
    output logic        o_cmd_err,
    output logic        o_go_stand,
    input  logic        i_spi_idle,
    output logic [10:0] o_tx_len,
    output logic [8:0]  o_wait_cyc,
    output logic [10:0] o_rx_len,
    output logic [7:0]  o_tx_data,
    output logic        o_tx_enqueue,
    input  logic        i_tx_ready,
    input  logic [7:0]  i_rx_data,
    input  logic        i_rx_avail,
    output logic        o_rx_dequeue
);

    localparam logic [1:0] c_OP_RDID = 2'b00;
    localparam logic [1:0] c_OP_READ = 2'b01;
    localparam logic [1:0] c_OP_PP   = 2'b10;
    localparam logic [1:0] c_OP_SSE  = 2'b11;

    localparam int c_POLL_W = (PARM_POLL_MAX < 2) ? 1 : $clog2(PARM_POLL_MAX + 1);
    localparam int c_GAP_W  = (PARM_POLL_GAP < 2) ? 1 : $clog2(PARM_POLL_GAP + 1);

    localparam logic [c_POLL_W-1:0] c_POLL_MAX = c_POLL_W'(PARM_POLL_MAX);
    localparam logic [c_GAP_W-1:0]  c_GAP_LAST =
        c_GAP_W'((PARM_POLL_GAP > 0) ? PARM_POLL_GAP - 1 : 0);

    // Index of the last PP byte (4 header bytes + 256 payload bytes).
    localparam logic [8:0] c_PP_LAST = 9'd259;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_WREN_LD  = 4'd1,
        S_WREN_GO  = 4'd2,
        S_WREN_WT  = 4'd3,
        S_CMD_LD   = 4'd4,
        S_DAT_LD   = 4'd5,
        S_CMD_GO   = 4'd6,
        S_CMD_WT   = 4'd7,
        S_POLL_GAP = 4'd8,
        S_POLL_LD  = 4'd9,
        S_POLL_GO  = 4'd10,
        S_POLL_WT  = 4'd11,
        S_DONE     = 4'd12
    } state_t;

    state_t                r_state_q,   w_state_d;
    logic [1:0]            r_op_q,      w_op_d;
    logic [23:0]           r_addr_q,    w_addr_d;
    logic [8:0]            r_idx_q,     w_idx_d;
    logic [1:0]            r_wt_q,      w_wt_d;
    logic [c_GAP_W-1:0]    r_gap_q,     w_gap_d;
    logic [c_POLL_W-1:0]   r_poll_q,    w_poll_d;
    logic                  r_stat_q,    w_stat_d;
    logic                  r_err_q,     w_err_d;
    logic [10:0]           r_tx_len_q,  w_tx_len_d;
    logic [10:0]           r_rx_len_q,  w_rx_len_d;
    logic [7:0]            r_rd_data_q, w_rd_data_d;
    logic                  r_rd_valid_q, w_rd_valid_d;

    logic                  w_rx_more;
    logic                  w_wt_ok;
    logic [c_POLL_W-1:0]   w_poll_inc;

    function automatic logic [10:0] f_tx_len(input logic [1:0] op);
        case (op)
            c_OP_RDID: f_tx_len = 11'd1;
            c_OP_READ: f_tx_len = 11'd4;
            c_OP_PP:   f_tx_len = 11'd260;
            default:   f_tx_len = 11'd4;
        endcase
    endfunction

    function automatic logic [10:0] f_rx_len(input logic [1:0] op);
        case (op)
            c_OP_RDID: f_rx_len = 11'd3;
            c_OP_READ: f_rx_len = 11'd256;
            default:   f_rx_len = 11'd0;
        endcase
    endfunction

    // Byte index doubles as the RX byte counter in the wait states.
    assign w_rx_more  = ({2'b00, r_idx_q} < r_rx_len_q);
    // The driver may not have dropped idle yet right after go; only trust
    // i_spi_idle once two cycles have passed in a wait state.
    assign w_wt_ok    = r_wt_q[1];
    assign w_poll_inc = (r_poll_q == c_POLL_MAX) ? r_poll_q : r_poll_q + 1'b1;

    always_comb begin
        w_state_d    = r_state_q;
        w_op_d       = r_op_q;
        w_addr_d     = r_addr_q;
        w_idx_d      = r_idx_q;
        w_wt_d       = r_wt_q;
        w_gap_d      = r_gap_q;
        w_poll_d     = r_poll_q;
        w_stat_d     = r_stat_q;
        w_err_d      = r_err_q;
        w_tx_len_d   = r_tx_len_q;
        w_rx_len_d   = r_rx_len_q;
        w_rd_data_d  = r_rd_data_q;
        w_rd_valid_d = 1'b0;
        o_tx_data    = 8'h00;
        o_tx_enqueue = 1'b0;
        o_go_stand   = 1'b0;
        o_rx_dequeue = 1'b0;
        o_wr_ready   = 1'b0;

        case (r_state_q)
            S_IDLE: begin
                if (i_cmd_valid) begin
                    w_op_d   = i_cmd_op;
                    w_addr_d = i_cmd_addr;
                    w_err_d  = 1'b0;
                    w_idx_d  = 9'd0;
                    w_poll_d = '0;
                    if (i_cmd_op[1]) begin
                        w_state_d  = S_WREN_LD;
                        w_tx_len_d = 11'd1;
                        w_rx_len_d = 11'd0;
                    end else begin
                        w_state_d  = S_CMD_LD;
                        w_tx_len_d = f_tx_len(i_cmd_op);
                        w_rx_len_d = f_rx_len(i_cmd_op);
                    end
                end
            end

            S_WREN_LD: begin
                o_tx_data = 8'h06;
                if (i_tx_ready) begin
                    o_tx_enqueue = 1'b1;
                    w_state_d    = S_WREN_GO;
                end
            end

            S_WREN_GO: begin
                if (i_spi_idle) begin
                    o_go_stand = 1'b1;
                    w_wt_d     = 2'd0;
                    w_state_d  = S_WREN_WT;
                end
            end

            S_WREN_WT: begin
                if (!w_wt_ok) begin
                    w_wt_d = r_wt_q + 2'd1;
                end else if (i_spi_idle) begin
                    w_state_d  = S_CMD_LD;
                    w_idx_d    = 9'd0;
                    w_tx_len_d = f_tx_len(r_op_q);
                    w_rx_len_d = f_rx_len(r_op_q);
                end
            end

            S_CMD_LD: begin
                case (r_idx_q[1:0])
                    2'd0: begin
                        case (r_op_q)
                            c_OP_RDID: o_tx_data = 8'h9F;
                            c_OP_READ: o_tx_data = 8'h03;
                            c_OP_PP:   o_tx_data = 8'h02;
                            default:   o_tx_data = 8'h20;
                        endcase
                    end
                    2'd1:    o_tx_data = r_addr_q[23:16];
                    2'd2:    o_tx_data = r_addr_q[15:8];
                    default: o_tx_data = r_addr_q[7:0];
                endcase
                if (i_tx_ready) begin
                    o_tx_enqueue = 1'b1;
                    w_idx_d      = r_idx_q + 9'd1;
                    if ((r_op_q == c_OP_RDID) ? (r_idx_q == 9'd0) : (r_idx_q == 9'd3)) begin
                        w_state_d = (r_op_q == c_OP_PP) ? S_DAT_LD : S_CMD_GO;
                    end
                end
            end

            S_DAT_LD: begin
                // Payload bytes go straight through; the index continues from 4
                // so the page ends at a fixed count of 260 transmitted bytes.
                o_tx_data    = i_wr_data;
                o_wr_ready   = i_wr_valid & i_tx_ready;
                o_tx_enqueue = i_wr_valid & i_tx_ready;
                if (i_wr_valid && i_tx_ready) begin
                    w_idx_d = r_idx_q + 9'd1;
                    if (r_idx_q == c_PP_LAST) begin
                        w_state_d = S_CMD_GO;
                    end
                end
            end

            S_CMD_GO: begin
                if (i_spi_idle) begin
                    o_go_stand = 1'b1;
                    w_idx_d    = 9'd0;
                    w_wt_d     = 2'd0;
                    w_state_d  = S_CMD_WT;
                end
            end

            S_CMD_WT: begin
                if (!w_wt_ok) begin
                    w_wt_d = r_wt_q + 2'd1;
                end
                if (w_rx_more && i_rx_avail) begin
                    o_rx_dequeue = 1'b1;
                    w_idx_d      = r_idx_q + 9'd1;
                    w_rd_valid_d = 1'b1;
                    w_rd_data_d  = i_rx_data;
                end else if (!w_rx_more && w_wt_ok && i_spi_idle) begin
                    w_gap_d   = '0;
                    w_state_d = r_op_q[1] ? S_POLL_GAP : S_DONE;
                end
            end

            S_POLL_GAP: begin
                if (r_gap_q == c_GAP_LAST) begin
                    w_gap_d    = '0;
                    w_tx_len_d = 11'd1;
                    w_rx_len_d = 11'd1;
                    w_state_d  = S_POLL_LD;
                end else begin
                    w_gap_d = r_gap_q + 1'b1;
                end
            end

            S_POLL_LD: begin
                o_tx_data = 8'h05;
                if (i_tx_ready) begin
                    o_tx_enqueue = 1'b1;
                    w_state_d    = S_POLL_GO;
                end
            end

            S_POLL_GO: begin
                if (i_spi_idle) begin
                    o_go_stand = 1'b1;
                    w_idx_d    = 9'd0;
                    w_wt_d     = 2'd0;
                    w_state_d  = S_POLL_WT;
                end
            end

            S_POLL_WT: begin
                if (!w_wt_ok) begin
                    w_wt_d = r_wt_q + 2'd1;
                end
                if (w_rx_more && i_rx_avail) begin
                    o_rx_dequeue = 1'b1;
                    w_idx_d      = r_idx_q + 9'd1;
                    w_stat_d     = i_rx_data[0];
                end else if (!w_rx_more && w_wt_ok && i_spi_idle) begin
                    w_poll_d = w_poll_inc;
                    if (!r_stat_q) begin
                        w_err_d   = 1'b0;
                        w_state_d = S_DONE;
                    end else if (w_poll_inc < c_POLL_MAX) begin
                        w_state_d = S_POLL_GAP;
                    end else begin
                        w_err_d   = 1'b1;
                        w_state_d = S_DONE;
                    end
                end
            end

            S_DONE: begin
                w_state_d = S_IDLE;
            end

            default: begin
                w_state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_arstn) begin
        if (!i_arstn) begin
            r_state_q    <= S_IDLE;
            r_op_q       <= 2'b00;
            r_addr_q     <= 24'd0;
            r_idx_q      <= 9'd0;
            r_wt_q       <= 2'd0;
            r_gap_q      <= '0;
            r_poll_q     <= '0;
            r_stat_q     <= 1'b0;
            r_err_q      <= 1'b0;
            r_tx_len_q   <= 11'd0;
            r_rx_len_q   <= 11'd0;
            r_rd_data_q  <= 8'h00;
            r_rd_valid_q <= 1'b0;
        end else begin
            r_state_q    <= w_state_d;
            r_op_q       <= w_op_d;
            r_addr_q     <= w_addr_d;
            r_idx_q      <= w_idx_d;
            r_wt_q       <= w_wt_d;
            r_gap_q      <= w_gap_d;
            r_poll_q     <= w_poll_d;
            r_stat_q     <= w_stat_d;
            r_err_q      <= w_err_d;
            r_tx_len_q   <= w_tx_len_d;
            r_rx_len_q   <= w_rx_len_d;
            r_rd_data_q  <= w_rd_data_d;
            r_rd_valid_q <= w_rd_valid_d;
        end
    end

    assign o_cmd_ready = (r_state_q == S_IDLE);
    assign o_cmd_done  = (r_state_q == S_DONE);
    assign o_cmd_err   = r_err_q;
    assign o_rd_data   = r_rd_data_q;
    assign o_rd_valid  = r_rd_valid_q;
    assign o_tx_len    = r_tx_len_q;
    assign o_rx_len    = r_rx_len_q;
    assign o_wait_cyc  = 9'd0;

endmodule
`default_nettype wire
